ntt_stage_scheduler: RTL and testbench

Sequencing controller for the accelerator's NTT/INTT butterfly datapath over a 256-coefficient, 12-bit (q = 3329) polynomial memory.
On a start pulse it walks all butterfly layers and issues one butterfly per cycle. Per butterfly it emits two coefficient read addresses and a twiddle (zeta) index.
It replays the addresses as write-back addresses after the butterfly pipeline latency, and drains the pipeline between layers to avoid read-after-write hazards.
It sits between the top-level polynomial FSM (which selects the mode and starts it) and the coefficient RAM / butterfly unit.

---
 rtl/ntt_stage_scheduler.sv | 175 +++++++++++++++++
 tb/tb_ntt_stage_scheduler.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler
//   Sequencing controller for the NTT/INTT butterfly datapath over an
//   N = 2**LOGN coefficient memory. A start pulse walks STAGES butterfly
//   layers and issues one butterfly per cycle. Between layers the pipeline
//   is drained for LAT cycles so a layer never reads a coefficient that the
//   previous layer has not yet written back.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      one-cycle request, sampled only while idle
//   mode       0 = forward NTT, 1 = inverse NTT (latched on accepted start)
//   stall      resource hold; suppresses issue while in the issue phase
//   rd_en      butterfly issue strobe
//   rd_addr_a  top coefficient address
//   rd_addr_b  bottom coefficient address (rd_addr_a + len)
//   tw_idx     twiddle ROM index
//   wr_en      write-back strobe, rd_en delayed LAT cycles
//   wr_addr_a  rd_addr_a delayed LAT cycles
//   wr_addr_b  rd_addr_b delayed LAT cycles
//   stage      current layer index
//   busy       high while issuing or draining
//   done       one-cycle completion pulse
//
// Handshake: rd_en is a valid strobe and stall acts as an inverted ready.
// A butterfly is issued (and the issue counter advances) exactly on an edge
// where the scheduler is issuing and stall is low; while stall is high the
// presented addresses and twiddle index hold their values.

module ntt_stage_scheduler #(
  parameter int LOGN   = 8,
  parameter int STAGES = 7,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              stall,
  output logic              rd_en,
  output logic [LOGN-1:0]   rd_addr_a,
  output logic [LOGN-1:0]   rd_addr_b,
  output logic [STAGES-1:0] tw_idx,
  output logic              wr_en,
  output logic [LOGN-1:0]   wr_addr_a,
  output logic [LOGN-1:0]   wr_addr_b,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done
);

  localparam int N    = 1 << LOGN;
  localparam int HALF = N / 2;
  localparam int CW   = $clog2(LAT + 1);
  localparam int DW   = 1 + 2 * LOGN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              mode_r;
  logic [2:0]        s;
  logic [LOGN-2:0]   b;
  logic [CW-1:0]     cnt;
  logic              in_issue;

  // Address / twiddle decode from the layer and butterfly counters.
  // len is always a power of two, so b / len and b % len reduce to a shift
  // and a mask by lg = log2(len).
  logic [3:0]        lg;
  logic [LOGN-1:0]   bx;
  logic [LOGN-1:0]   len;
  logic [LOGN-1:0]   g;
  logic [LOGN-1:0]   j;
  logic [LOGN-1:0]   base;
  logic [STAGES-1:0] tw_c;

  always_comb begin
    bx = {1'b0, b};
    if (mode_r) lg = 4'(LOGN - STAGES) + {1'b0, s};
    else        lg = 4'(LOGN - 1) - {1'b0, s};
    len  = LOGN'(1) << lg;
    g    = bx >> lg;
    j    = bx & (len - LOGN'(1));
    base = (g << (lg + 4'd1)) | j;
    // Inverse twiddles count down from the top of the index range; in the
    // first inverse layer 1 << STAGES wraps to 0 in STAGES bits, which still
    // yields the intended (2**STAGES - 1 - g).
    if (mode_r) tw_c = (STAGES'(1) << (4'(STAGES) - {1'b0, s})) - STAGES'(1) - STAGES'(g);
    else        tw_c = (STAGES'(1) << s) + STAGES'(g);
  end

  assign in_issue  = (state == ST_ISSUE);
  assign rd_en     = in_issue && !stall;
  assign rd_addr_a = in_issue ? base : '0;
  assign rd_addr_b = in_issue ? (base + len) : '0;
  assign tw_idx    = in_issue ? tw_c : '0;
  assign stage     = s;

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      mode_r <= 1'b0;
      s      <= '0;
      b      <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_r <= mode;
            s      <= '0;
            b      <= '0;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!stall) begin
            if (b == (LOGN-1)'(HALF - 1)) begin
              cnt   <= CW'(LAT);
              state <= ST_DRAIN;
            end else begin
              b <= b + (LOGN-1)'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (cnt == CW'(1)) begin
            if (s == 3'(STAGES - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              s     <= s + 3'd1;
              b     <= '0;
              state <= ST_ISSUE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write-back delay line. Free-running so that stall never reorders or
  // duplicates write-backs; cleared by reset so in-flight writes are dropped.
  logic [DW-1:0] dl [LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) dl[i] <= '0;
    end else begin
      dl[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = dl[LAT-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Testbench for ntt_stage_scheduler: randomized stalls and modes, a
// behavioural issue-order model, an expected queue of butterflies and a
// negedge monitor that compares every DUT output cycle by cycle.

module tb_ntt_stage_scheduler;

  localparam int LOGN   = 8;
  localparam int STAGES = 7;
  localparam int LAT    = 4;
  localparam int N      = 1 << LOGN;
  localparam int HALF   = N / 2;
  localparam int TOTAL  = STAGES * HALF;

  // ---------------- clock / reset / DUT ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic mode  = 1'b0;
  logic stall = 1'b0;

  logic              rd_en;
  logic [LOGN-1:0]   rd_addr_a;
  logic [LOGN-1:0]   rd_addr_b;
  logic [STAGES-1:0] tw_idx;
  logic              wr_en;
  logic [LOGN-1:0]   wr_addr_a;
  logic [LOGN-1:0]   wr_addr_b;
  logic [2:0]        stage;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  ntt_stage_scheduler #(.LOGN(LOGN), .STAGES(STAGES), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .stall     (stall),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [25:0] exp_q[$];      // {stage, tw, addr_a, addr_b} per issued butterfly
  logic [16:0] wr_exp_q[$];   // {en, addr_a, addr_b} expected on rd side each cycle

  logic        mon_en     = 1'b0;
  logic        exp_en     = 1'b0;
  logic        exp_busy   = 1'b0;
  logic        exp_done   = 1'b0;
  logic        exp_hold   = 1'b0;
  logic [7:0]  exp_hold_a = '0;
  logic [7:0]  exp_hold_b = '0;
  logic [16:0] exp_cur    = '0;
  int          wr_cnt     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: butterfly (s, b) straight from the layer-length definition.
  function automatic logic [25:0] model(input logic m, input int s, input int bb);
    int len, g, j, a, tw;
    if (m) len = 1 << (LOGN - STAGES + s);
    else   len = N / (1 << (s + 1));
    g = bb / len;
    j = bb % len;
    a = 2 * g * len + j;
    if (m) tw = (1 << (STAGES - s)) - 1 - g;
    else   tw = (1 << s) + g;
    return {3'(s), 7'(tw), 8'(a), 8'(a + len)};
  endfunction

  // ---------------- monitor ----------------
  logic [25:0] mon_e;
  logic [16:0] mon_w;

  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_en", int'(rd_en), int'(exp_en));
      check("busy", int'(busy), int'(exp_busy));
      check("done", int'(done), int'(exp_done));
      if (rd_en) begin
        check("issue_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("issue_tuple", int'({stage, tw_idx, rd_addr_a, rd_addr_b}), int'(mon_e));
        end
      end
      if (exp_hold) begin
        check("stall_hold_a", int'(rd_addr_a), int'(exp_hold_a));
        check("stall_hold_b", int'(rd_addr_b), int'(exp_hold_b));
      end
      wr_exp_q.push_back(exp_cur);
      if (wr_exp_q.size() > LAT) begin
        mon_w = wr_exp_q.pop_front();
        if (mon_w[16]) check("wr_tuple", int'({wr_en, wr_addr_a, wr_addr_b}), int'(mon_w));
        else           check("wr_en_idle", int'(wr_en), 0);
      end
      if (wr_en) wr_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_exp();
    exp_en   = 1'b0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_hold = 1'b0;
    exp_cur  = '0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    stall = 1'b0;
    clear_exp();
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_rd_addr_a"}, int'(rd_addr_a), 0);
    check({tag, "_rd_addr_b"}, int'(rd_addr_b), 0);
    check({tag, "_tw_idx"}, int'(tw_idx), 0);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_wr_addr_a"}, int'(wr_addr_a), 0);
  endtask

  task automatic do_abort();
    mon_en = 1'b0;
    start  = 1'b0;
    stall  = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(posedge clk); #1;
    check("rst_hold_wr_en", int'(wr_en), 0);
    check("rst_hold_rd_en", int'(rd_en), 0);
    rst = 1'b1;
    exp_q.delete();
    wr_exp_q.delete();
    clear_exp();
    mon_en = 1'b1;
    idle(3);
  endtask

  // One transform. Stall pattern: random percentage plus an optional fixed
  // window [fix_at, fix_at+fix_len) counted in cycles after the start edge.
  // mid_start: cycle with a start pulse (opposite mode) that must be ignored.
  // abort_at: butterfly count at which reset is asserted (-1 = never).
  task automatic run(input logic m, input int stall_pct, input int fix_at,
                     input int fix_len, input int mid_start, input int abort_at);
    int          issued;
    int          drain_left;
    int          k;
    bit          fin;
    logic        st;
    logic [25:0] te;
    issued     = 0;
    drain_left = 0;
    fin        = 1'b0;
    wr_cnt     = 0;
    clear_exp();
    start = 1'b1;
    mode  = m;
    stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom);
    k = 1;
    while (!fin) begin
      if (abort_at >= 0 && issued == abort_at) begin
        do_abort();
        return;
      end
      st = (stall_pct > 0 && int'($urandom_range(99)) < stall_pct) ||
           (k >= fix_at && k < fix_at + fix_len);
      stall = st;
      start = (k == mid_start);
      if (start) mode = ~m;
      clear_exp();
      exp_busy = 1'b1;
      if (drain_left > 0) begin
        drain_left--;
      end else if (issued == TOTAL) begin
        exp_busy = 1'b0;
        exp_done = 1'b1;
        start    = 1'b1;
        mode     = ~m;
        fin      = 1'b1;
      end else begin
        te = model(m, issued / HALF, issued % HALF);
        if (st) begin
          exp_hold   = 1'b1;
          exp_hold_a = te[15:8];
          exp_hold_b = te[7:0];
        end else begin
          exp_en  = 1'b1;
          exp_cur = {1'b1, te[15:0]};
          exp_q.push_back(te);
          issued++;
          if (issued % HALF == 0) drain_left = LAT;
        end
      end
      @(posedge clk); #1;
      k++;
      if (k > 5000) begin
        check("run_cycle_bound", k, 0);
        fin = 1'b1;
      end
    end
    idle(LAT + 4);
    check("queue_drained", exp_q.size(), 0);
    check("wr_count", wr_cnt, TOTAL);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    mon_en = 1'b1;
    idle(2);

    run(1'b0, 0, -1, 0, -1, -1);                 // forward, no stall
    run(1'b1, 0, -1, 0, -1, -1);                 // inverse, no stall
    // layer 2, b = 50 issues on cycle 2*(HALF+LAT)+50+1 without stalls
    run(1'($urandom), 0, 2 * (HALF + LAT) + 51, 10, 60, -1);
    run(1'($urandom), 25, -1, 0, 300, -1);       // random stalls
    run(1'b0, 0, -1, 0, -1, 3 * HALF + 40);      // reset mid layer 3
    run(1'($urandom), 10, -1, 0, -1, -1);        // clean run after reset

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
